coin_payout: RTL

COIN_PAYOUT -- requirements
Module: coin_payout

---
 rtl/coin_payout.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/coin_payout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : coin_payout                                                |
// | Description : Change dispenser sequencer. Pays the owed amount (in       |
// |               nickels) as timed dime/nickel pulses on a 2-bit coin bus,  |
// |               preferring dimes and skipping empty tubes. It ends with a  |
// |               one-clock done pulse and a short flag if change is unpaid. |
// |               Optional feature macro: COIN_PAYOUT_COUNT_EN adds the      |
// |               8-bit coins_paid counter output.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module coin_payout #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       dime_empty,
  input  logic       nickel_empty,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic       short
`ifdef COIN_PAYOUT_COUNT_EN
  ,
  output logic [7:0] coins_paid
`endif
);

  localparam logic [1:0] c_coin_none   = 2'b00;
  localparam logic [1:0] c_coin_nickel = 2'b01;
  localparam logic [1:0] c_coin_dime   = 2'b10;

  // Phase counter counts down to zero, so it reloads with length minus one.
  localparam logic [7:0] c_hold_reload = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] c_gap_reload  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] remaining_q, remaining_d;
  logic [7:0] phase_q, phase_d;
  logic [1:0] coin_q, coin_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       short_q, short_d;

  logic       select_now;
  logic [4:0] sel_rem;
  logic [1:0] sel_coin;

  // Dime first (largest coin that fits), nickel as fallback, else nothing.
  function automatic logic [1:0] select_coin(input logic [4:0] rem,
                                             input logic       d_empty,
                                             input logic       n_empty);
    if (rem >= 5'd2 && !d_empty) begin
      return c_coin_dime;
    end else if (rem != 5'd0 && !n_empty) begin
      return c_coin_nickel;
    end
    return c_coin_none;
  endfunction

  // Next-state and registered-output logic; selection is shared by IDLE and GAP exit.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    coin_d      = coin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    short_d     = 1'b0;
    select_now  = 1'b0;
    sel_rem     = remaining_q;
    sel_coin    = c_coin_none;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = amount;
          sel_rem     = amount;
          select_now  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q == 8'd0) begin
          state_d     = ST_GAP;
          coin_d      = c_coin_none;
          remaining_d = remaining_q - ((coin_q == c_coin_dime) ? 5'd2 : 5'd1);
          phase_d     = c_gap_reload;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (phase_q == 8'd0) begin
          select_now = 1'b1;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        coin_d  = c_coin_none;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        coin_d  = c_coin_none;
      end
    endcase

    if (select_now) begin
      // Empty flags are only looked at here, so a coin already in flight is unaffected.
      sel_coin = select_coin(sel_rem, dime_empty, nickel_empty);
      busy_d   = 1'b1;
      if (sel_coin != c_coin_none) begin
        state_d = ST_HOLD;
        coin_d  = sel_coin;
        phase_d = c_hold_reload;
      end else begin
        state_d = ST_DONE;
        coin_d  = c_coin_none;
        done_d  = 1'b1;
        short_d = (sel_rem != 5'd0);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 5'd0;
      phase_q     <= 8'd0;
      coin_q      <= c_coin_none;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      coin_q      <= coin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      short_q     <= short_d;
    end
  end

  assign coin  = coin_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign short = short_q;

`ifdef COIN_PAYOUT_COUNT_EN
  logic [7:0] paid_q, paid_d;

  // Count every completed coin pulse; wraps naturally at 8 bits.
  always_comb begin
    paid_d = paid_q;
    if (state_q == ST_HOLD && phase_q == 8'd0) begin
      paid_d = paid_q + 8'd1;
    end
  end

  // Paid-coin counter register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      paid_q <= 8'd0;
    end else begin
      paid_q <= paid_d;
    end
  end

  assign coins_paid = paid_q;
`endif

endmodule
`default_nettype wire
